// File: rtl/bin2x2_filter_if.sv
// ---------------------------------------------------------------------------
// bin2x2_filter_if
//   Stream bundle for the 2x2 binning stage: cropped pixel stream in
//   (ready/valid) and binned pixel stream out (ready/valid + last).
//
//   pixel_in  / in_valid  / in_ready  : upstream pixel stream
//   pixel_out / out_valid / out_ready : downstream binned stream
//   out_last                          : marks the last binned pixel of a frame
//
//   master : side that feeds pixels and consumes binned output
//   slave  : the binning stage itself
// ---------------------------------------------------------------------------
interface bin2x2_filter_if #(
    parameter int PIXEL_BIT_WIDTH = 12
);
    logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
    logic                       in_valid;
    logic                       in_ready;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport master (
        output pixel_in, in_valid, out_ready,
        input  in_ready, pixel_out, out_valid, out_last
    );

    modport slave (
        input  pixel_in, in_valid, out_ready,
        output in_ready, pixel_out, out_valid, out_last
    );
endinterface

// File: rtl/bin2x2_filter.sv
// ---------------------------------------------------------------------------
// bin2x2_filter
//   Consumes a cropped IN_ROWS x IN_COLS raster pixel stream and emits an
//   IN_ROWS/2 x IN_COLS/2 image, each output the mean of one 2x2 block.
//   Horizontal pair sums of even rows are parked in a line buffer and
//   combined with the matching pair of the following odd row.
//
//   Ports:
//     clk      : clock, all state on rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : bin2x2_filter_if.slave (pixel_in/in_valid/in_ready,
//                pixel_out/out_valid/out_ready/out_last)
//
//   Build option:
//     BIN_ROUND_EN defined   -> pixel_out = (sum + 2) >> 2 (round half up)
//     BIN_ROUND_EN undefined -> pixel_out = sum >> 2       (truncate)
// ---------------------------------------------------------------------------
module bin2x2_filter #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bin2x2_filter_if.slave        bus
);
    localparam int W        = PIXEL_BIT_WIDTH;
    localparam int XW       = (IN_COLS > 2) ? $clog2(IN_COLS) : 1;
    localparam int YW       = (IN_ROWS > 2) ? $clog2(IN_ROWS) : 1;
    localparam int LB_DEPTH = IN_COLS / 2;
    localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IN_COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_ROWS - 1);

    generate
        if ((IN_ROWS % 2 != 0) || (IN_COLS % 2 != 0) || (IN_ROWS < 2) || (IN_COLS < 2)) begin : g_bad_geometry
            $error("bin2x2_filter: IN_ROWS and IN_COLS must be even and >= 2");
        end
    endgenerate

    // Position of the next pixel to be accepted within the frame.
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    // Left pixel of the current horizontal pair.
    logic [W-1:0]  h_q, h_d;
    // Output register.
    logic [W-1:0]  pixel_out_q, pixel_out_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q,  out_last_d;

    // Pair sums of the last even row, one entry per output column.
    logic [W:0]    linebuf_q [LB_DEPTH];

    logic          accept;
    logic          load;
    logic          lb_we;
    logic [LW-1:0] lb_idx;
    logic [W:0]    hsum;
    logic [W+1:0]  sum;
    logic [W+1:0]  sum_adj;
    logic [W-1:0]  binned;

    // The output slot frees up when it is empty or being popped this cycle,
    // so a pop and a load can share one cycle without a bubble.
    assign bus.in_ready  = bus.out_ready | ~out_valid_q;
    assign accept        = bus.in_valid & bus.in_ready;

    assign bus.pixel_out = pixel_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    // Even rows write an entry, odd rows read it: never the same cycle.
    assign lb_idx = LW'(x_q >> 1);
    assign hsum   = {1'b0, h_q} + {1'b0, bus.pixel_in};
    assign sum    = {1'b0, linebuf_q[lb_idx]} + {1'b0, hsum};

`ifdef BIN_ROUND_EN
    // Max (4*(2^W-1)+2) still fits W+2 bits, and >>2 stays within W bits.
    assign sum_adj = sum + (W+2)'(2);
`else
    assign sum_adj = sum;
`endif
    assign binned  = W'(sum_adj >> 2);

    assign lb_we = accept &  x_q[0] & ~y_q[0];
    assign load  = accept &  x_q[0] &  y_q[0];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        h_d         = h_q;
        pixel_out_d = pixel_out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (accept) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end

            if (!x_q[0]) begin
                h_d = bus.pixel_in;
            end
        end

        if (load) begin
            pixel_out_d = binned;
            out_valid_d = 1'b1;
            out_last_d  = (x_q == X_LAST) && (y_q == Y_LAST);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= '0;
            y_q         <= '0;
            h_q         <= '0;
            pixel_out_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            h_q         <= h_d;
            pixel_out_q <= pixel_out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // NOTE: the line buffer has no reset; every entry is written on an even
    // row before the odd row that reads it, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= hsum;
        end
    end
endmodule

// File: tb/tb_bin2x2_filter.sv
// ---------------------------------------------------------------------------
// tb_bin2x2_filter
//   Directed bench for bin2x2_filter at 20x20 -> 10x10, 12-bit pixels.
//   Expected outputs come from a per-block mean model of the stimulus
//   pattern plus a few hand-computed values.
// ---------------------------------------------------------------------------
module tb_bin2x2_filter;
    localparam int W    = 12;
    localparam int ROWS = 20;
    localparam int COLS = 20;
    localparam int OPF  = (ROWS / 2) * (COLS / 2);
    localparam int IPF  = ROWS * COLS;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bin2x2_filter_if #(.PIXEL_BIT_WIDTH(W)) bus ();

    bin2x2_filter #(
        .PIXEL_BIT_WIDTH(W),
        .IN_ROWS        (ROWS),
        .IN_COLS        (COLS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [W-1:0] got_pix [$];
    bit           got_last[$];
    bit           rand_ready = 1'b0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus patterns: 0 = constant c, 1 = ramp x, 2 = ramp x+y.
    function automatic int unsigned pix_val(input int pat, input int c, input int x, input int y);
        case (pat)
            0:       return c;
            1:       return x;
            default: return x + y;
        endcase
    endfunction

    function automatic int unsigned exp_bin(input int pat, input int c, input int r, input int col);
        int unsigned s;
        s = pix_val(pat, c, 2*col,   2*r)   + pix_val(pat, c, 2*col+1, 2*r)
          + pix_val(pat, c, 2*col,   2*r+1) + pix_val(pat, c, 2*col+1, 2*r+1);
`ifdef BIN_ROUND_EN
        s = s + 2;
`endif
        return s >> 2;
    endfunction

    // Output monitor: a handshake completes at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got_pix.push_back(bus.pixel_out);
                got_last.push_back(bus.out_last);
            end
        end
    end

    // Random downstream back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drive_frame(input int pat, input int c, input bit gaps, input int npix);
        int timeouts;
        int waited;
        int x;
        int y;
        timeouts = 0;
        for (int k = 0; k < npix; k++) begin
            x = k % COLS;
            y = (k / COLS) % ROWS;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            bus.pixel_in = W'(pix_val(pat, c, x, y));
            bus.in_valid = 1'b1;
            waited = 0;
            forever begin
                @(negedge clk);
                if (bus.in_ready) break;
                waited++;
                if (waited > 1000) begin
                    timeouts++;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("drive_timeout", timeouts, 0);
    endtask

    task automatic wait_outputs(input int n, input string tag);
        int waited;
        waited = 0;
        while (got_pix.size() < n && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check(tag, got_pix.size(), n);
    endtask

    task automatic check_frames(input int pat, input int c, input int nframes);
        int idx;
        for (int k = 0; k < got_pix.size() && k < nframes * OPF; k++) begin
            idx = k % OPF;
            check($sformatf("pix[%0d]", k), got_pix[k], exp_bin(pat, c, idx / (COLS/2), idx % (COLS/2)));
            check($sformatf("last[%0d]", k), got_last[k], (idx == OPF - 1) ? 1 : 0);
        end
    endtask

    task automatic clear_outputs();
        got_pix.delete();
        got_last.delete();
    endtask

    task automatic stall_outputs();
        int waited;
        logic [W-1:0] held_pix;
        logic         held_last;
        waited = 0;
        while (!bus.out_valid && waited < 1000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("stall_first_valid", bus.out_valid, 1);
        held_pix  = bus.pixel_out;
        held_last = bus.out_last;
        repeat (10) begin
            check("stall_in_ready", bus.in_ready,  0);
            check("stall_valid",    bus.out_valid, 1);
            check("stall_pix_hold", bus.pixel_out, held_pix);
            check("stall_last_hold", bus.out_last, held_last);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pixel_in  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        reset_n       = 1'b0;

        // Reset state.
        #12;
        check("rst_pixel_out", bus.pixel_out, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last",  bus.out_last,  0);
        check("rst_in_ready",  bus.in_ready,  1);
        #5 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: constant 100 frame.
        drive_frame(0, 100, 1'b0, IPF);
        wait_outputs(OPF, "const100_count");
        check_frames(0, 100, 1);
        clear_outputs();

        // 2: ramp x, bin column j -> 2j (truncate) or 2j+1 (round).
        drive_frame(1, 0, 1'b0, IPF);
        wait_outputs(OPF, "ramp_count");
`ifdef BIN_ROUND_EN
        check("ramp_col0", got_pix[0],  1);
        check("ramp_col9", got_pix[19], 19);
`else
        check("ramp_col0", got_pix[0],  0);
        check("ramp_col9", got_pix[19], 18);
`endif
        check_frames(1, 0, 1);
        clear_outputs();

        // 3: full-scale frame, no wrap.
        drive_frame(0, 4095, 1'b0, IPF);
        wait_outputs(OPF, "max_count");
        check("max_first", got_pix[0], 4095);
        check_frames(0, 4095, 1);
        clear_outputs();

        // 4: downstream stalled for 10 cycles after the first output.
        bus.out_ready = 1'b0;
        fork
            drive_frame(2, 0, 1'b0, IPF);
            stall_outputs();
        join
        wait_outputs(OPF, "stall_count");
        check_frames(2, 0, 1);
        clear_outputs();

        // 5: asynchronous reset after 57 accepted pixels.
        drive_frame(0, 50, 1'b0, 57);
        check("partial_count", got_pix.size(), 10);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_pixel_out", bus.pixel_out, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_last",  bus.out_last,  0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_outputs();
        drive_frame(0, 200, 1'b0, IPF);
        wait_outputs(OPF, "after_rst_count");
        check_frames(0, 200, 1);
        clear_outputs();

        // 6: random input gaps and back-pressure over two back-to-back frames.
        rand_ready = 1'b1;
        drive_frame(2, 0, 1'b1, 2 * IPF);
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        wait_outputs(2 * OPF, "random_count");
        check_frames(2, 0, 2);
        clear_outputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
